// File: rtl/reg_writeback_unit_pkg.sv
// rtl/reg_writeback_unit_pkg.sv - shared constants and writeback entry type (package rf_pkg)
package rf_pkg;

    localparam int NUM_REGS      = 4;
    localparam int DATA_WIDTH    = 36;
    localparam int ADDRESS_WIDTH = $clog2(NUM_REGS);
    localparam int FIFO_DEPTH    = 4;
    localparam int PTR_WIDTH     = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - result, register-file write and operand-read signals of the writeback unit
interface reg_writeback_unit_if;
    import rf_pkg::*;

    logic                     i_res_valid;
    logic                     o_res_ready;
    logic [ADDRESS_WIDTH-1:0] i_res_rd;
    logic [DATA_WIDTH-1:0]    i_res_data;
    logic                     i_hold;
    logic [ADDRESS_WIDTH-1:0] o_rf_rd;
    logic [DATA_WIDTH-1:0]    o_rf_wdata;
    logic                     o_rf_wen;
    logic [ADDRESS_WIDTH-1:0] i_rs1;
    logic [ADDRESS_WIDTH-1:0] i_rs2;
    logic [DATA_WIDTH-1:0]    i_rs1_rf_data;
    logic [DATA_WIDTH-1:0]    i_rs2_rf_data;
    logic [DATA_WIDTH-1:0]    o_rs1_data;
    logic [DATA_WIDTH-1:0]    o_rs2_data;
    logic                     o_rs1_hazard;
    logic                     o_rs2_hazard;
    logic [NUM_REGS-1:0]      o_pending;
    logic [CNT_WIDTH-1:0]     o_count;

    // The writeback unit itself
    modport slave (
        input  i_res_valid, i_res_rd, i_res_data, i_hold,
        input  i_rs1, i_rs2, i_rs1_rf_data, i_rs2_rf_data,
        output o_res_ready, o_rf_rd, o_rf_wdata, o_rf_wen,
        output o_rs1_data, o_rs2_data, o_rs1_hazard, o_rs2_hazard,
        output o_pending, o_count
    );

    // Execute / operand-read side driving the unit
    modport master (
        output i_res_valid, i_res_rd, i_res_data, i_hold,
        output i_rs1, i_rs2, i_rs1_rf_data, i_rs2_rf_data,
        input  o_res_ready, o_rf_rd, o_rf_wdata, o_rf_wen,
        input  o_rs1_data, o_rs2_data, o_rs1_hazard, o_rs2_hazard,
        input  o_pending, o_count
    );

endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// rtl/reg_writeback_unit_wb_fifo.sv - writeback buffer (module wb_fifo) with age-ordered read port
module wb_fifo
    import rf_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  wb_entry_t                        push_entry_i,
    input  logic                             pop_i,
    output wb_entry_t                        head_o,
    output logic [CNT_WIDTH-1:0]             count_o,
    output wb_entry_t [FIFO_DEPTH-1:0]       age_entry_o,
    output logic [FIFO_DEPTH-1:0]            age_valid_o
);

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    wb_entry_t            mem_q [FIFO_DEPTH];

    // Pointer and occupancy next state; pointers wrap naturally since depth is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared immediately on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful where the occupancy says so
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Age view: slot 0 is the youngest entry, walking backward from the write pointer
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        idx = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx            = wr_ptr_q - PTR_WIDTH'(k + 1);
            age_entry_o[k] = mem_q[idx];
            age_valid_o[k] = (CNT_WIDTH'(k) < count_q);
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - writeback buffer, pending tracking and operand resolution (optional RWB_BYPASS_EN)
module reg_writeback_unit
    import rf_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    reg_writeback_unit_if.slave bus
);

    logic                       push;
    logic                       pop;
    wb_entry_t                  head;
    logic [CNT_WIDTH-1:0]       count;
    wb_entry_t [FIFO_DEPTH-1:0] age_entry;
    logic [FIFO_DEPTH-1:0]      age_valid;
    logic [CNT_WIDTH-1:0]       ctr_q [NUM_REGS];
    logic [CNT_WIDTH-1:0]       ctr_d [NUM_REGS];
    logic [NUM_REGS-1:0]        pending;

    // No push-through when full: readiness depends only on current occupancy
    assign bus.o_res_ready = (count != CNT_WIDTH'(FIFO_DEPTH));
    assign push            = bus.i_res_valid && bus.o_res_ready;
    assign pop             = (count != '0) && !bus.i_hold && !i_rst;

    assign bus.o_rf_wen    = pop;
    assign bus.o_rf_rd     = head.rd;
    assign bus.o_rf_wdata  = head.data;
    assign bus.o_count     = count;
    assign bus.o_pending   = pending;

    wb_fifo u_fifo (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .push_i       (push),
        .push_entry_i ({bus.i_res_rd, bus.i_res_data}),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .age_entry_o  (age_entry),
        .age_valid_o  (age_valid)
    );

    // Per-register count of buffered writes; push and pop of the same register cancel
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ctr_d[r] = ctr_q[r];
            if (push && (bus.i_res_rd == ADDRESS_WIDTH'(r))) ctr_d[r] = ctr_d[r] + CNT_WIDTH'(1);
            if (pop && (head.rd == ADDRESS_WIDTH'(r)))       ctr_d[r] = ctr_d[r] - CNT_WIDTH'(1);
            pending[r] = (ctr_q[r] != '0);
        end
    end

    // Per-register counters, cleared immediately on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) ctr_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) ctr_q[r] <= ctr_d[r];
        end
    end

`ifdef RWB_BYPASS_EN
    // Forward the youngest buffered value for each operand (including the head being written now)
    always_comb begin
        bus.o_rs1_data   = bus.i_rs1_rf_data;
        bus.o_rs2_data   = bus.i_rs2_rf_data;
        bus.o_rs1_hazard = 1'b0;
        bus.o_rs2_hazard = 1'b0;
        for (int k = FIFO_DEPTH - 1; k >= 0; k--) begin
            if (age_valid[k] && (age_entry[k].rd == bus.i_rs1)) bus.o_rs1_data = age_entry[k].data;
            if (age_valid[k] && (age_entry[k].rd == bus.i_rs2)) bus.o_rs2_data = age_entry[k].data;
        end
    end
`else
    logic unused_age;
    assign unused_age = ^{age_entry, age_valid};

    // Without forwarding, an operand with a buffered write is a hazard the caller must stall on
    always_comb begin
        bus.o_rs1_data   = bus.i_rs1_rf_data;
        bus.o_rs2_data   = bus.i_rs2_rf_data;
        bus.o_rs1_hazard = pending[bus.i_rs1];
        bus.o_rs2_hazard = pending[bus.i_rs2];
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - scoreboard bench for reg_writeback_unit (honours RWB_BYPASS_EN)
module tb_reg_writeback_unit;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    reg_writeback_unit_if bus ();

    reg_writeback_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: buffered results in arrival order, and architectural register contents
    wb_entry_t             mdl[$];
    logic [DATA_WIDTH-1:0] arch  [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_tb [NUM_REGS];

    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin
            arch[r]  = '0;
            rf_tb[r] = '0;
        end
    end

    assign bus.i_rs1_rf_data = rf_tb[bus.i_rs1];
    assign bus.i_rs2_rf_data = rf_tb[bus.i_rs2];

    // Register file attached to the write port
    always @(posedge clk) begin
        if (bus.o_rf_wen) rf_tb[bus.o_rf_rd] <= bus.o_rf_wdata;
    end

    // Reference model update: oldest result retires when not held, new result enters if room
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl.delete();
        end else begin
            int sz;
            sz = mdl.size();
            if (sz != 0 && !bus.i_hold) begin
                arch[mdl[0].rd] <= mdl[0].data;
                void'(mdl.pop_front());
            end
            if (bus.i_res_valid && sz < FIFO_DEPTH)
                mdl.push_back({bus.i_res_rd, bus.i_res_data});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] youngest(input logic [ADDRESS_WIDTH-1:0] rs);
        logic [DATA_WIDTH-1:0] v;
        v = arch[rs];
        foreach (mdl[i]) if (mdl[i].rd == rs) v = mdl[i].data;
        return v;
    endfunction

    function automatic logic buffered(input logic [ADDRESS_WIDTH-1:0] rs);
        logic b;
        b = 1'b0;
        foreach (mdl[i]) if (mdl[i].rd == rs) b = 1'b1;
        return b;
    endfunction

    task automatic monitor_check();
        logic [NUM_REGS-1:0] exp_pend;
        exp_pend = '0;
        foreach (mdl[i]) exp_pend[mdl[i].rd] = 1'b1;
        chk("count",   64'(bus.o_count),     64'(mdl.size()));
        chk("ready",   64'(bus.o_res_ready), 64'(mdl.size() != FIFO_DEPTH));
        chk("pending", 64'(bus.o_pending),   64'(exp_pend));
        chk("rf_wen",  64'(bus.o_rf_wen),    64'(mdl.size() != 0 && !bus.i_hold && !rst));
        if (mdl.size() != 0) begin
            chk("rf_rd",    64'(bus.o_rf_rd),    64'(mdl[0].rd));
            chk("rf_wdata", 64'(bus.o_rf_wdata), 64'(mdl[0].data));
        end else begin
            chk("rf_rd_empty",    64'(bus.o_rf_rd),    64'(0));
            chk("rf_wdata_empty", 64'(bus.o_rf_wdata), 64'(0));
        end
`ifdef RWB_BYPASS_EN
        chk("rs1_data", 64'(bus.o_rs1_data),   64'(youngest(bus.i_rs1)));
        chk("rs2_data", 64'(bus.o_rs2_data),   64'(youngest(bus.i_rs2)));
        chk("rs1_haz",  64'(bus.o_rs1_hazard), 64'(0));
        chk("rs2_haz",  64'(bus.o_rs2_hazard), 64'(0));
`else
        chk("rs1_data", 64'(bus.o_rs1_data),   64'(arch[bus.i_rs1]));
        chk("rs2_data", 64'(bus.o_rs2_data),   64'(arch[bus.i_rs2]));
        chk("rs1_haz",  64'(bus.o_rs1_hazard), 64'(buffered(bus.i_rs1)));
        chk("rs2_haz",  64'(bus.o_rs2_hazard), 64'(buffered(bus.i_rs2)));
`endif
    endtask

    // Monitor samples on the falling edge, away from the capture edge
    always @(negedge clk) monitor_check();

    task automatic drive(input logic v, input logic [ADDRESS_WIDTH-1:0] rd,
                         input logic [DATA_WIDTH-1:0] d, input logic h,
                         input logic [ADDRESS_WIDTH-1:0] r1, input logic [ADDRESS_WIDTH-1:0] r2);
        bus.i_res_valid = v;
        bus.i_res_rd    = rd;
        bus.i_res_data  = d;
        bus.i_hold      = h;
        bus.i_rs1       = r1;
        bus.i_rs2       = r2;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] rnd_data();
        return {4'($urandom), $urandom};
    endfunction

    initial begin
        bus.i_res_valid = 1'b0;
        bus.i_res_rd    = '0;
        bus.i_res_data  = '0;
        bus.i_hold      = 1'b0;
        bus.i_rs1       = '0;
        bus.i_rs2       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(bus.o_count),     64'(0));
        chk("rst_wen",   64'(bus.o_rf_wen),    64'(0));
        chk("rst_ready", 64'(bus.o_res_ready), 64'(1));
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Single result into empty buffer
        drive(1, 2, 36'h1_2345_6789, 0, 2, 0);
        chk("t1_wen",   64'(bus.o_rf_wen),   64'(1));
        chk("t1_rd",    64'(bus.o_rf_rd),    64'(2));
        chk("t1_wdata", 64'(bus.o_rf_wdata), 64'h1_2345_6789);
        drive(0, 0, 0, 0, 2, 0);
        chk("t1_pend",  64'(bus.o_pending),  64'(0));
        chk("t1_rf2",   64'(rf_tb[2]),       64'h1_2345_6789);

        // Fill while held, refuse a fifth, then drain in order
        for (int i = 0; i < 4; i++) drive(1, 2'(i), 36'(100 + i), 1, 0, 1);
        chk("t2_ready", 64'(bus.o_res_ready), 64'(0));
        chk("t2_count", 64'(bus.o_count),     64'(4));
        chk("t2_pend",  64'(bus.o_pending),   64'b1111);
        drive(1, 0, 36'h999, 1, 0, 1);
        chk("t2_count5", 64'(bus.o_count), 64'(4));
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 2, 3);
        for (int i = 0; i < 4; i++) chk("t2_rf", 64'(rf_tb[i]), 64'(100 + i));

        // Two writes to R1, operand read of R1 while held
        drive(1, 1, 36'd5, 1, 1, 0);
        drive(1, 1, 36'd9, 1, 1, 0);
`ifdef RWB_BYPASS_EN
        chk("t3_fwd", 64'(bus.o_rs1_data),   64'(9));
        chk("t3_haz", 64'(bus.o_rs1_hazard), 64'(0));
`else
        chk("t3_haz", 64'(bus.o_rs1_hazard), 64'(1));
`endif
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
        chk("t3_rf1", 64'(rf_tb[1]), 64'(9));

        // Full with drain and valid: refused, then accepted next cycle, then wrap
        for (int i = 0; i < 4; i++) drive(1, 2'(3 - i), rnd_data(), 1, 0, 0);
        bus.i_hold = 1'b0;
        #1;
        chk("t4_ready", 64'(bus.o_res_ready), 64'(0));
        drive(1, 0, 36'h0AA, 0, 0, 0);
        chk("t4_count", 64'(bus.o_count),     64'(3));
        chk("t4_ready2", 64'(bus.o_res_ready), 64'(1));
        for (int i = 0; i < 2 * FIFO_DEPTH + 1; i++) drive(1, 2'($urandom), rnd_data(), 0, 2'($urandom), 2'($urandom));
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);

        // Reset mid-cycle with three buffered entries
        for (int i = 0; i < 3; i++) drive(1, 2'(i), rnd_data(), 1, 0, 0);
        bus.i_hold = 1'b0;
        bus.i_res_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t5_wen",   64'(bus.o_rf_wen),    64'(0));
        chk("t5_count", 64'(bus.o_count),     64'(0));
        chk("t5_pend",  64'(bus.o_pending),   64'(0));
        chk("t5_ready", 64'(bus.o_res_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_res_valid = 1'b0;
        chk("t5_rf0", 64'(rf_tb[0]), 64'(arch[0]));
        drive(0, 0, 0, 0, 0, 0);

        // Push and pop of R3 in the same cycle
        drive(1, 3, 36'h33, 1, 3, 0);
        drive(1, 3, 36'h34, 0, 3, 0);
        chk("t6_pend3", 64'(bus.o_pending[3]), 64'(1));
        chk("t6_count", 64'(bus.o_count),      64'(1));
        drive(0, 0, 0, 0, 3, 0);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                bus.i_hold = 1'b0;
                #2 rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 2) != 0), 2'($urandom), rnd_data(),
                  1'($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom));
        end
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < NUM_REGS; r++) chk("final_rf", 64'(rf_tb[r]), 64'(arch[r]));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
